// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset clear sequence, optional write-to-read
// bypass, a hardwired-zero register 0, a trigger-driven system register and a pending-write scoreboard.
module regfile_mp #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int NUM_RD  = 2,
    parameter int FWD     = 1,
    parameter int SYS_REG = 17,
    parameter int A0_REG  = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       trigger,
    input  logic                       iss_valid,
    input  logic [ADDR_W-1:0]          iss_rd,
    output logic [(2**ADDR_W)-1:0]     pend,
    output logic                       ready,
    output logic [DATA_W-1:0]          a0
);

    localparam int NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] SYS_A  = ADDR_W'(SYS_REG);
    localparam logic [ADDR_W-1:0] A0_A   = ADDR_W'(A0_REG);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NREG - 1);
    localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t                state_r, state_s;
    logic [ADDR_W-1:0]     idx_r, idx_s;
    logic                  ready_r;
    logic [NREG-1:0]       pend_r, pend_s;
    logic [DATA_W-1:0]     mem_r [NREG];
    logic                  run_s, we_eff_s, trig_eff_s, iss_eff_s;
    logic [NUM_RD*DATA_W-1:0] rd_data_s;

    // Writes only commit in RUN with reset released; trigger outranks a we write to SYS_REG.
    assign run_s      = rst_n && (state_r == RUN);
    assign trig_eff_s = run_s && trigger;
    assign we_eff_s   = run_s && we && (wr_addr != ZERO_A) && !(trigger && (wr_addr == SYS_A));
    assign iss_eff_s  = run_s && iss_valid && (iss_rd != ZERO_A);

    // Next-state logic: walk idx across every register, then settle in RUN.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            CLEAR: begin
                idx_s = idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (idx_r == LAST_A) state_s = RUN;
                else                 state_s = CLEAR;
            end
            RUN: begin
                state_s = RUN;
                idx_s   = idx_r;
            end
            default: begin
                state_s = CLEAR;
                idx_s   = ZERO_A;
            end
        endcase
    end

    // Scoreboard update: a committed write clears its bit, an issue sets it and wins on a tie.
    always_comb begin
        pend_s = {NREG{1'b0}};
        for (int i = 1; i < NREG; i++) begin
            pend_s[i] = (iss_eff_s && (iss_rd == ADDR_W'(i))) ||
                        (pend_r[i] && !((we_eff_s && (wr_addr == ADDR_W'(i))) ||
                                        (trig_eff_s && (SYS_A == ADDR_W'(i)))));
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= CLEAR;
            idx_r   <= ZERO_A;
            ready_r <= 1'b0;
            pend_r  <= {NREG{1'b0}};
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            ready_r <= (state_s == RUN);
            pend_r  <= pend_s;
        end
    end

    // Register storage: untouched by reset, zeroed one entry per cycle during CLEAR.
    always_ff @(posedge clk) begin
        if (rst_n && (state_r == CLEAR)) begin
            mem_r[idx_r] <= {DATA_W{1'b0}};
        end else begin
            if (we_eff_s)   mem_r[wr_addr] <= wr_data;
            if (trig_eff_s) mem_r[SYS_A]   <= {{(DATA_W-1){1'b0}}, 1'b1};
        end
    end

    // Asynchronous read ports with optional bypass of this cycle's write.
    always_comb begin
        rd_data_s = {(NUM_RD*DATA_W){1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            if (state_r == CLEAR || rd_addr[k*ADDR_W +: ADDR_W] == ZERO_A) begin
                rd_data_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end else if ((FWD != 0) && trig_eff_s && (rd_addr[k*ADDR_W +: ADDR_W] == SYS_A)) begin
                rd_data_s[k*DATA_W +: DATA_W] = {{(DATA_W-1){1'b0}}, 1'b1};
            end else if ((FWD != 0) && we_eff_s && (rd_addr[k*ADDR_W +: ADDR_W] == wr_addr)) begin
                rd_data_s[k*DATA_W +: DATA_W] = wr_data;
            end else begin
                rd_data_s[k*DATA_W +: DATA_W] = mem_r[rd_addr[k*ADDR_W +: ADDR_W]];
            end
        end
    end

    assign rd_data = rd_data_s;
    assign pend    = pend_r;
    assign ready   = ready_r;
    assign a0      = mem_r[A0_A];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing and a non-bypassing instance share
// all stimulus; table vectors cover RUN behaviour, hand sequences cover clear/reset.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data_nf;
    logic        we, trigger, iss_valid;
    logic [4:0]  wr_addr, iss_rd;
    logic [31:0] wr_data;
    logic [31:0] pend, pend_nf;
    logic        ready, ready_nf;
    logic [31:0] a0, a0_nf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .trigger(trigger),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .pend(pend), .ready(ready), .a0(a0)
    );

    regfile_mp #(.FWD(0)) dut_nf (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nf),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .trigger(trigger),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .pend(pend_nf), .ready(ready_nf), .a0(a0_nf)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        trig;
        logic        iv;
        logic [4:0]  ir;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [31:0] e_nf0;
        logic [31:0] e_a0_pre;
        logic [31:0] e_pend;
        logic [31:0] e_a0;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        trigger = 1'b0; iss_valid = 1'b0; iss_rd = 5'd0;
    endtask

    initial begin
        int n;
        //        we    wa     wd            trig  iv    ir     ra0    ra1    rd0           rd1           nf0           a0_pre  pend          a0
        tv[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0,  32'h0,        32'h0};
        tv[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,  32'h0,        32'h0};
        tv[2]  = '{1'b1, 5'd0,  32'h1234,     1'b0, 1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'h0,  32'h0,        32'h0};
        tv[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd17, 5'd17, 5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'h0,  32'h00020000, 32'h0};
        tv[4]  = '{1'b1, 5'd17, 32'hFF,       1'b1, 1'b0, 5'd0,  5'd17, 5'd17, 32'h1,        32'h1,        32'h0,        32'h0,  32'h0,        32'h0};
        tv[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  5'd17, 5'd5,  32'h1,        32'hDEADBEEF, 32'h1,        32'h0,  32'h0,        32'h0};
        tv[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd10, 5'd10, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,  32'h00000400, 32'h0};
        tv[7]  = '{1'b1, 5'd10, 32'h55,       1'b0, 1'b1, 5'd10, 5'd10, 5'd17, 32'h55,       32'h1,        32'h0,        32'h0,  32'h00000400, 32'h55};
        tv[8]  = '{1'b1, 5'd10, 32'h66,       1'b0, 1'b0, 5'd0,  5'd10, 5'd0,  32'h66,       32'h0,        32'h55,       32'h55, 32'h0,        32'h66};
        tv[9]  = '{1'b1, 5'd3,  32'h77,       1'b0, 1'b1, 5'd0,  5'd3,  5'd0,  32'h77,       32'h0,        32'h0,        32'h66, 32'h0,        32'h66};
        tv[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd3,  5'd3,  5'd0,  32'h77,       32'h0,        32'h77,       32'h66, 32'h00000008, 32'h66};
        tv[11] = '{1'b1, 5'd17, 32'hABC,      1'b0, 1'b0, 5'd0,  5'd17, 5'd3,  32'hABC,      32'h77,       32'h1,        32'h66, 32'h00000008, 32'h66};
        tv[12] = '{1'b1, 5'd3,  32'h88,       1'b1, 1'b1, 5'd5,  5'd17, 5'd3,  32'h1,        32'h88,       32'hABC,      32'h66, 32'h00000020, 32'h66};

        idle_inputs();
        rd_addr = 10'd0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_pend", pend, 32'd0);
        chk("reset_pend_nf", pend_nf, 32'd0);

        // Release reset while hammering writes/trigger/issue that CLEAR must ignore.
        we = 1'b1; wr_addr = 5'd3; wr_data = 32'hAAAA;
        trigger = 1'b1; iss_valid = 1'b1; iss_rd = 5'd4;
        rd_addr = {5'd17, 5'd3};
        rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i < 32) begin
                if (ready !== 1'b0) chk($sformatf("clear_ready_e%0d", i), {31'd0, ready}, 32'd0);
                else checks++;
            end else begin
                chk("clear_ready_e32", {31'd0, ready}, 32'd1);
            end
            if (i == 16) begin
                chk("clear_rd0", rd_data[31:0], 32'd0);
                chk("clear_rd1", rd_data[63:32], 32'd0);
                chk("clear_pend", pend, 32'd0);
            end
        end
        idle_inputs();
        #1;
        chk("post_clear_rd3", rd_data[31:0], 32'd0);
        chk("post_clear_rd17", rd_data[63:32], 32'd0);
        chk("post_clear_pend", pend, 32'd0);
        chk("post_clear_a0", a0, 32'd0);
        chk("post_clear_ready_nf", {31'd0, ready_nf}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            we = tv[i].we; wr_addr = tv[i].wa; wr_data = tv[i].wd;
            trigger = tv[i].trig; iss_valid = tv[i].iv; iss_rd = tv[i].ir;
            rd_addr = {tv[i].ra1, tv[i].ra0};
            #1;
            chk($sformatf("v%0d_rd0", i), rd_data[31:0], tv[i].e_rd0);
            chk($sformatf("v%0d_rd1", i), rd_data[63:32], tv[i].e_rd1);
            chk($sformatf("v%0d_nf_rd0", i), rd_data_nf[31:0], tv[i].e_nf0);
            chk($sformatf("v%0d_a0_pre", i), a0, tv[i].e_a0_pre);
            tick();
            chk($sformatf("v%0d_pend", i), pend, tv[i].e_pend);
            chk($sformatf("v%0d_a0", i), a0, tv[i].e_a0);
            chk($sformatf("v%0d_nf_pend", i), pend_nf, tv[i].e_pend);
            idle_inputs();
        end

        // Write reg3 together with an issue to reg3: set wins, then reset mid-RUN.
        we = 1'b1; wr_addr = 5'd3; wr_data = 32'h77; iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        idle_inputs();
        rd_addr = {5'd0, 5'd3};
        #1;
        chk("pre_rst_reg3", rd_data[31:0], 32'h77);
        chk("pre_rst_pend3", {31'd0, pend[3]}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rst_run_pend", pend, 32'd0);
        chk("rst_run_ready", {31'd0, ready}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("mid_clear_ready", {31'd0, ready}, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("restart_clear_edges", n, 32'd32);
        chk("post_rst_reg3", rd_data[31:0], 32'd0);
        chk("post_rst_reg3_nf", rd_data_nf[31:0], 32'd0);
        chk("post_rst_a0", a0, 32'd0);
        chk("post_rst_pend", pend, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The parameter ADDR_W SHALL default to 5 and set the register address width, giving 2**ADDR_W registers.
REQ-002 The parameter DATA_W SHALL default to 32 and set the register data width.
REQ-003 The parameter NUM_RD SHALL default to 2, accept values 1..4, and set the number of independent read ports.
REQ-004 The parameter FWD SHALL default to 1, where 1 enables write-to-read bypass and 0 disables it.
REQ-005 The parameter SYS_REG SHALL default to 17 and name the register that the trigger input targets.
REQ-006 The parameter A0_REG SHALL default to 10 and name the register mirrored on a0.
REQ-007 The block SHALL have one clock and a synchronous, active-low reset, with ports `clk` (in, 1, rising-edge clock) and `rst_n` (in, 1, synchronous active-low reset).
REQ-008 The port `rd_addr` SHALL be an input of NUM_RD*ADDR_W bits, with port k occupying bits [k*ADDR_W +: ADDR_W].
REQ-009 The port `rd_data` SHALL be an output of NUM_RD*DATA_W bits, with port k occupying bits [k*DATA_W +: DATA_W].
REQ-010 The write port SHALL consist of `we` (in, 1, write enable), `wr_addr` (in, ADDR_W, write address) and `wr_data` (in, DATA_W, write data).
REQ-011 The port `trigger` SHALL be a 1-bit input that requests the system write of register SYS_REG.
REQ-012 The issue port SHALL consist of `iss_valid` (in, 1) and `iss_rd` (in, ADDR_W, destination being issued).
REQ-013 The port `pend` SHALL be an output of 2**ADDR_W bits holding the scoreboard pending-write mask.
REQ-014 The port `ready` SHALL be a 1-bit output that is high once the post-reset clear sequence is done.
REQ-015 The port `a0` SHALL be a DATA_W-bit output equal to the stored value of register A0_REG.

Function
REQ-016 The block SHALL have two states, CLEAR and RUN, held in a state register together with an ADDR_W-bit clear index `idx`.
REQ-017 On each rising clk edge in CLEAR with rst_n high, the block SHALL write 0 to reg[idx] and increment idx.
REQ-018 When idx equals 2**ADDR_W-1, the block SHALL perform that last clear and move to RUN on the same edge.
REQ-019 The ready output SHALL be registered and equal (state==RUN), so ready first reads 1 exactly 2**ADDR_W edges after rst_n is released.
REQ-020 In CLEAR, we, trigger and iss_valid SHALL be ignored, and every rd_data port SHALL read 0.
REQ-021 Reads SHALL be combinational and asynchronous on each port: rd_data[k] = reg[rd_addr[k]].
REQ-022 Register 0 SHALL be hardwired to 0: reads of address 0 return 0 and writes to address 0 are dropped without error.
REQ-023 In RUN, when we=1 and wr_addr!=0, the block SHALL write wr_data to reg[wr_addr] at the rising edge.
REQ-024 In RUN, when trigger=1, the block SHALL write 1 (zero-extended to DATA_W) to reg[SYS_REG] at the rising edge.
REQ-025 When trigger=1 and a we write targets SYS_REG in the same cycle, the trigger write SHALL win and the we write to SYS_REG SHALL be dropped.
REQ-026 When FWD=1 in RUN, a read port whose address is non-zero and equals the register being written this cycle SHALL return the value that will be written (wr_data, or 1 for a trigger write to SYS_REG).
REQ-027 When FWD=0, a read port SHALL return the old stored value until the write edge has occurred.
REQ-028 Bypass SHALL apply to every read port independently and SHALL NOT apply to the a0 output, which reflects stored state only.
REQ-029 In RUN, iss_valid=1 with iss_rd!=0 SHALL set pend[iss_rd] at the rising edge.
REQ-030 A committed write, from either we or trigger, SHALL clear the pend bit of its target register at the rising edge.
REQ-031 When a set and a clear hit the same pend index in the same cycle, the set SHALL win.
REQ-032 The bit pend[0] SHALL be constantly 0.

Reset
REQ-033 When rst_n=0 at a rising edge, the block SHALL set state=CLEAR, idx=0, ready=0 and pend=0, and SHALL leave register contents untouched; the clear sequence then zeroes them.
REQ-034 Reset asserted mid-CLEAR or mid-RUN SHALL restart the clear sequence from idx=0.
REQ-035 After the clear sequence completes, every register, rd_data port and a0 SHALL read 0.
REQ-036 No state SHALL change while rst_n=0 beyond the assignments of REQ-033.

Verification
REQ-037 Scenario: release rst_n, default parameters -> ready=0 for 32 edges and =1 from edge 32; all reads and a0 read 0; writes issued during CLEAR are lost.
REQ-038 Scenario: in RUN, we=1, wr_addr=5, wr_data=0xDEADBEEF, rd_addr[0]=5 in the same cycle -> rd_data[0]=0xDEADBEEF combinationally when FWD=1 and the old value when FWD=0; after the edge both configurations read 0xDEADBEEF.
REQ-039 Scenario: we=1, wr_addr=0, wr_data=0x1234 -> rd_addr=0 still reads 0 and pend[0]=0.
REQ-040 Scenario: trigger=1 together with we=1, wr_addr=17, wr_data=0xFF -> reg17=0x1 after the edge, and pend[17] is cleared.
REQ-041 Scenario: iss_valid=1, iss_rd=10 -> pend[10]=1; then we=1 to reg 10 with 0x55 together with iss_valid=1, iss_rd=10 -> pend[10] stays 1 and a0=0x55.
REQ-042 Scenario: assert rst_n=0 after reg 3 holds 0x77 and pend[3]=1 -> pend=0 and ready=0 immediately; after 32 edges reg3=0.
